// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: control-flow kinds, BTB entry layout,
// 2-bit counter encodings and index/tag helpers.
package bp_types;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_BR   = 2'd1,
    CF_JAL  = 2'd2,
    CF_JALR = 2'd3
  } cf_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag field is sized for the smallest possible table so one struct serves any BTB depth.
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic                 uncond;
  } btb_entry_t;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int entries);
    return 30 - $clog2(entries);
  endfunction

  function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int idx_bits);
    return TAG_MAX_W'(pc >> (idx_bits + 2));
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup + execute resolution bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(parameter int BHT_IDX_W = 8);
  import bp_types::*;

  logic [31:0]          IF_pc;
  logic                 IF_pred_taken;
  logic [31:0]          IF_pred_target;
  logic [BHT_IDX_W-1:0] IF_pred_bht_idx;

  logic                 EX_valid;
  logic                 stall_execute;
  logic [31:0]          EX_pc;
  cf_t                  EX_cf_type;
  logic                 EX_taken;
  logic [31:0]          EX_target_pc;
  logic                 EX_pred_taken;
  logic [31:0]          EX_pred_target;
  logic [BHT_IDX_W-1:0] EX_bht_idx;
  logic                 EX_mispredict;
  logic [31:0]          EX_redirect_pc;

  logic [31:0]          bp_branch_count;
  logic [31:0]          bp_mispred_count;

  modport master (
    output IF_pc, EX_valid, stall_execute, EX_pc, EX_cf_type, EX_taken, EX_target_pc,
           EX_pred_taken, EX_pred_target, EX_bht_idx,
    input  IF_pred_taken, IF_pred_target, IF_pred_bht_idx, EX_mispredict, EX_redirect_pc,
           bp_branch_count, bp_mispred_count
  );

  modport slave (
    input  IF_pc, EX_valid, stall_execute, EX_pc, EX_cf_type, EX_taken, EX_target_pc,
           EX_pred_taken, EX_pred_target, EX_bht_idx,
    output IF_pred_taken, IF_pred_target, IF_pred_bht_idx, EX_mispredict, EX_redirect_pc,
           bp_branch_count, bp_mispred_count
  );

endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB: combinational lookup port, one clocked write/invalidate port.
// Only valid bits are reset; tag/target contents are don't-care while invalid.
module bp_btb
  import bp_types::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_rd_pc,
  output logic        o_rd_hit,
  output logic [31:0] o_rd_target,
  output logic        o_rd_uncond,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_pc,
  input  logic [31:0] i_wr_target,
  input  logic        i_wr_uncond,
  input  logic        i_clr_en
);

  localparam int IDX_W = idx_w(ENTRIES);

  logic [ENTRIES-1:0]   r_valid;
  logic [ENTRIES-1:0]   r_uncond;
  logic [TAG_MAX_W-1:0] r_tag    [ENTRIES];
  logic [31:0]          r_target [ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_hit;
  btb_entry_t       w_rd_entry;

  assign w_rd_idx   = i_rd_pc[IDX_W+1:2];
  assign w_wr_idx   = i_wr_pc[IDX_W+1:2];
  assign w_rd_entry = '{valid:  r_valid[w_rd_idx],
                        tag:    r_tag[w_rd_idx],
                        target: r_target[w_rd_idx],
                        uncond: r_uncond[w_rd_idx]};

  assign o_rd_hit    = w_rd_entry.valid & (w_rd_entry.tag == pc_tag(i_rd_pc, IDX_W));
  assign o_rd_target = w_rd_entry.target;
  assign o_rd_uncond = w_rd_entry.uncond;

  // Invalidation only removes an entry that really belongs to the resolving PC, not an alias.
  assign w_wr_hit = r_valid[w_wr_idx] & (r_tag[w_wr_idx] == pc_tag(i_wr_pc, IDX_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end else if (i_clr_en && w_wr_hit) begin
      r_valid[w_wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]    <= pc_tag(i_wr_pc, IDX_W);
      r_target[w_wr_idx] <= i_wr_target;
      r_uncond[w_wr_idx] <= i_wr_uncond;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor (BTB + 2-bit BHT): zero-latency lookup, trains one cycle after EX resolve.
// Stall on EX blocks training; define BP_GSHARE_EN to XOR a global history into the BHT index.
module branch_predictor
  import bp_types::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int BHT_ENTRIES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);

  localparam int BHT_IDX_W = idx_w(BHT_ENTRIES);

  logic [1:0]  r_bht [BHT_ENTRIES];
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  logic                 w_upd;
  logic                 w_is_br;
  logic                 w_is_cf;
  logic                 w_btb_hit;
  logic                 w_btb_uncond;
  logic [31:0]          w_btb_target;
  logic                 w_pred_taken;
  logic                 w_mispredict;
  logic [BHT_IDX_W-1:0] w_pc_idx;
  logic [BHT_IDX_W-1:0] w_bht_idx;

  assign w_upd    = bp.EX_valid & ~bp.stall_execute;
  assign w_is_br  = (bp.EX_cf_type == CF_BR);
  assign w_is_cf  = (bp.EX_cf_type != CF_NONE);
  assign w_pc_idx = bp.IF_pc[BHT_IDX_W+1:2];

`ifdef BP_GSHARE_EN
  logic [BHT_IDX_W-1:0] r_ghr;

  // History follows resolved outcomes only, so it never needs repair after a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_upd && w_is_br) begin
      r_ghr <= {r_ghr[BHT_IDX_W-2:0], bp.EX_taken};
    end
  end

  assign w_bht_idx = w_pc_idx ^ r_ghr;
`else
  assign w_bht_idx = w_pc_idx;
`endif

  bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_pc     (bp.IF_pc),
    .o_rd_hit    (w_btb_hit),
    .o_rd_target (w_btb_target),
    .o_rd_uncond (w_btb_uncond),
    .i_wr_en     (w_upd & w_is_cf & bp.EX_taken),
    .i_wr_pc     (bp.EX_pc),
    .i_wr_target (bp.EX_target_pc),
    .i_wr_uncond (~w_is_br),
    .i_clr_en    (w_upd & ~w_is_cf)
  );

  assign w_pred_taken = w_btb_hit & (w_btb_uncond | r_bht[w_bht_idx][1]);
  assign w_mispredict = w_upd & ((bp.EX_pred_taken != bp.EX_taken) |
                                 (bp.EX_taken & (bp.EX_pred_target != bp.EX_target_pc)));

  assign bp.IF_pred_taken    = w_pred_taken;
  assign bp.IF_pred_target   = w_pred_taken ? w_btb_target : bp.IF_pc + 32'd4;
  assign bp.IF_pred_bht_idx  = w_bht_idx;
  assign bp.EX_mispredict    = w_mispredict;
  assign bp.EX_redirect_pc   = bp.EX_target_pc;
  assign bp.bp_branch_count  = r_branch_cnt;
  assign bp.bp_mispred_count = r_mispred_cnt;

  // Train with the index captured at fetch so bimodal and gshare share one update path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= WNT;
    end else if (w_upd && w_is_br) begin
      r_bht[bp.EX_bht_idx] <= ctr_next(r_bht[bp.EX_bht_idx], bp.EX_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_upd && w_is_cf) r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (w_mispredict)     r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

endmodule
